alu_issue: RTL
==============

Name: alu_issue

Overview:
- Issue/writeback front end for the BEAN integer ALU: accepts one decoded RV64I integer instruction and maps it to an `ALU_OP_*` code and operand pair.
- Drives the ALU's op/rs1/rs2/enable inputs, captures the registered result, and sign-extends 32-bit (W) results.
- Presents the result to the register-file writeback port through a valid/ready handshake.
- Sits between the decode stage and the ALU; one instruction in flight.

Parameters:
- XPR_LEN, 64, data path width (from BEAN.cfg)
- W_LEN, 32, word width for W-type operations
- ALU_OP_WIDTH, from ALU.cfg, width of ALU op code

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  unit can accept an instruction
- in_opcode  in  7  instruction bits [6:0]
- in_funct3  in  3  instruction bits [14:12]
- in_funct7  in  7  instruction bits [31:25]
- in_rd  in  5  destination register index
- in_rs1_val  in  XPR_LEN  rs1 value
- in_rs2_val  in  XPR_LEN  rs2 value
- in_imm  in  XPR_LEN  sign-extended immediate (I/U format per opcode)
- in_pc  in  XPR_LEN  instruction PC (AUIPC)
- alu_op  out  ALU_OP_WIDTH  op code to ALU
- alu_rs1  out  XPR_LEN  ALU operand 1
- alu_rs2  out  XPR_LEN  ALU operand 2
- alu_en  out  1  ALU enable
- alu_rd  in  XPR_LEN  ALU registered result
- wb_valid  out  1  writeback valid
- wb_ready  in  1  register file accepts writeback
- wb_rd  out  5  writeback index
- wb_data  out  XPR_LEN  writeback value
- wb_we  out  1  write enable (0 for x0 or illegal)
- wb_illegal  out  1  instruction not legal for this unit
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0 except in_ready=1; an in-flight instruction is discarded with no writeback.
- States:
  - IDLE: in_ready=1. On in_valid, latch decoded op, operands, rd and flags. Go to ISSUE; go to WB directly if illegal.
  - ISSUE: alu_en=1 with registered alu_op/alu_rs1/alu_rs2 for exactly one cycle. Go to CAPT.
  - CAPT: alu_en=0. Sample alu_rd, sign-extend if W (bits [63:32] = bit 31), register into wb_data. Go to WB.
  - WB: wb_valid=1; wb_rd, wb_data, wb_we, wb_illegal held stable. When wb_ready=1, go to IDLE.
- Timing: accept in cycle N; alu_en in N+1; wb_valid from N+3. Next accept no earlier than the cycle after the wb handshake; in_ready=0 outside IDLE.
- alu_op/alu_rs1/alu_rs2 are 0 whenever alu_en=0.
- OP (0110011), OP-IMM (0010011), operand2 = rs2 or imm, by funct3:
  - 000: ADD; SUB only when OP and funct7=0100000.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when funct7[5]=1.
  - 110: OR.
  - 111: AND.
  - funct7 legality for OP: only 0000000, or 0100000 for SUB/SRA.
  - funct7 legality for OP-IMM shifts: funct7[6:1] must be 000000 or 010000 (SRAI only); funct7[0] is shamt[5].
- OP-32 (0111011), OP-IMM-32 (0011011):
  - 000: ADD, or SUB (SUBW, OP-32 only); result sign-extended from bit 31.
  - 001: SLLW.
  - 101: SRLW, or SRAW when funct7=0100000.
  - Operand2 bit 5 forced to 0 for W shifts.
  - funct7 must be exactly 0000000, or 0100000 where noted.
  - Other funct3 are illegal.
- LUI (0110111): ADD, rs1=0, rs2=imm.
- AUIPC (0010111): ADD, rs1=in_pc, rs2=imm.
- Illegal (any other opcode/encoding): no ALU issue; WB with wb_illegal=1, wb_we=0, wb_data=0.
- wb_we = legal && (in_rd != 0).
- wb_ready held low: WB holds indefinitely with outputs unchanged.

Test Plan:
- ADD rs1=5, rs2=7, rd=3 -> alu_en one cycle at N+1 with the ADD op; wb_valid at N+3, wb_data=12, wb_we=1, wb_rd=3.
- SUBW rs1=0, rs2=1 -> wb_data=0xFFFF_FFFF_FFFF_FFFF.
- SRAIW rs1=0x0000_0000_8000_0000, imm shamt=4 -> wb_data=0xFFFF_FFFF_F800_0000.
- SLLW rs1=1, rs2=0x21 -> alu_rs2=0x01, wb_data=2.
- OP funct7=0000001 (MUL encoding) -> no alu_en; wb_illegal=1, wb_we=0.
- ADDI to rd=0 with wb_ready low 3 cycles -> wb_valid and outputs stable for 3 cycles, wb_we=0, in_ready=0; IDLE one cycle after wb_ready.
- rst asserted in ISSUE -> outputs 0 immediately, in_ready=1, no wb_valid afterwards.

Source files
------------

// File: rtl/alu_issue_if.sv
// Bundle of the decode-side, ALU-side and writeback-side signals of the
// integer ALU issue/writeback front end. The unit itself uses the slave
// modport; the surrounding pipeline (decode, ALU, register file) uses master.
interface alu_issue_if #(
   parameter int XPR_LEN      = 64,
   parameter int ALU_OP_WIDTH = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [6:0]              in_opcode;
   logic [2:0]              in_funct3;
   logic [6:0]              in_funct7;
   logic [4:0]              in_rd;
   logic [XPR_LEN-1:0]      in_rs1_val;
   logic [XPR_LEN-1:0]      in_rs2_val;
   logic [XPR_LEN-1:0]      in_imm;
   logic [XPR_LEN-1:0]      in_pc;
   logic [ALU_OP_WIDTH-1:0] alu_op;
   logic [XPR_LEN-1:0]      alu_rs1;
   logic [XPR_LEN-1:0]      alu_rs2;
   logic                    alu_en;
   logic [XPR_LEN-1:0]      alu_rd;
   logic                    wb_valid;
   logic                    wb_ready;
   logic [4:0]              wb_rd;
   logic [XPR_LEN-1:0]      wb_data;
   logic                    wb_we;
   logic                    wb_illegal;
   logic                    busy;

   modport master (
      output in_valid, in_opcode, in_funct3, in_funct7, in_rd,
             in_rs1_val, in_rs2_val, in_imm, in_pc, alu_rd, wb_ready,
      input  in_ready, alu_op, alu_rs1, alu_rs2, alu_en,
             wb_valid, wb_rd, wb_data, wb_we, wb_illegal, busy
   );

   modport slave (
      input  in_valid, in_opcode, in_funct3, in_funct7, in_rd,
             in_rs1_val, in_rs2_val, in_imm, in_pc, alu_rd, wb_ready,
      output in_ready, alu_op, alu_rs1, alu_rs2, alu_en,
             wb_valid, wb_rd, wb_data, wb_we, wb_illegal, busy
   );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback front end for the BEAN integer ALU. Takes one decoded RV64I
// integer instruction, drives the ALU for a single cycle, captures and
// (for W forms) sign-extends the result, then offers it to the register file.
module alu_issue #(
   parameter int XPR_LEN      = 64,
   parameter int W_LEN        = 32,
   parameter int ALU_OP_WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   alu_issue_if.slave bus
);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = ALU_OP_WIDTH'(0);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = ALU_OP_WIDTH'(1);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = ALU_OP_WIDTH'(2);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = ALU_OP_WIDTH'(3);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = ALU_OP_WIDTH'(4);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = ALU_OP_WIDTH'(5);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = ALU_OP_WIDTH'(6);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = ALU_OP_WIDTH'(7);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = ALU_OP_WIDTH'(8);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = ALU_OP_WIDTH'(9);

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_CAPT  = 2'd2;
   localparam logic [1:0] ST_WB    = 2'd3;

   logic [1:0]              state;
   logic [ALU_OP_WIDTH-1:0] op_r;
   logic [XPR_LEN-1:0]      rs1_r;
   logic [XPR_LEN-1:0]      rs2_r;
   logic                    en_r;
   logic                    w_r;
   logic [4:0]              rd_r;
   logic                    we_r;
   logic                    ill_r;
   logic [XPR_LEN-1:0]      data_r;

   logic [ALU_OP_WIDTH-1:0] dec_op;
   logic [XPR_LEN-1:0]      dec_rs1;
   logic [XPR_LEN-1:0]      dec_rs2;
   logic                    dec_legal;
   logic                    dec_w;
   logic                    is_imm;
   logic                    f7_zero;
   logic                    f7_alt;

   assign is_imm  = (bus.in_opcode == OPC_OP_IMM) || (bus.in_opcode == OPC_OP_IMM_32);
   assign f7_zero = (bus.in_funct7 == 7'b0000000);
   assign f7_alt  = (bus.in_funct7 == 7'b0100000);

   // Decode the incoming instruction into an ALU op, operand pair and legality.
   // W right shifts pre-extend rs1 from bit 31 so a 64-bit ALU shift yields the
   // correct low word (sign fill for SRAW, zero fill for SRLW).
   always_comb begin
      dec_op    = ALU_OP_ADD;
      dec_rs1   = bus.in_rs1_val;
      dec_rs2   = bus.in_rs2_val;
      dec_legal = 1'b0;
      dec_w     = 1'b0;
      case (bus.in_opcode)
         OPC_OP, OPC_OP_IMM: begin
            if (is_imm) dec_rs2 = bus.in_imm;
            case (bus.in_funct3)
               3'b000: begin
                  dec_legal = is_imm || f7_zero || f7_alt;
                  if (!is_imm && f7_alt) dec_op = ALU_OP_SUB;
               end
               3'b001: begin
                  dec_op    = ALU_OP_SLL;
                  dec_legal = is_imm ? (bus.in_funct7[6:1] == 6'b000000) : f7_zero;
               end
               3'b010: begin
                  dec_op    = ALU_OP_SLT;
                  dec_legal = is_imm || f7_zero;
               end
               3'b011: begin
                  dec_op    = ALU_OP_SLTU;
                  dec_legal = is_imm || f7_zero;
               end
               3'b100: begin
                  dec_op    = ALU_OP_XOR;
                  dec_legal = is_imm || f7_zero;
               end
               3'b101: begin
                  dec_op    = bus.in_funct7[5] ? ALU_OP_SRA : ALU_OP_SRL;
                  dec_legal = is_imm ? ((bus.in_funct7[6:1] == 6'b000000) ||
                                        (bus.in_funct7[6:1] == 6'b010000))
                                     : (f7_zero || f7_alt);
               end
               3'b110: begin
                  dec_op    = ALU_OP_OR;
                  dec_legal = is_imm || f7_zero;
               end
               default: begin
                  dec_op    = ALU_OP_AND;
                  dec_legal = is_imm || f7_zero;
               end
            endcase
         end
         OPC_OP_32, OPC_OP_IMM_32: begin
            dec_w = 1'b1;
            if (is_imm) dec_rs2 = bus.in_imm;
            case (bus.in_funct3)
               3'b000: begin
                  dec_legal = is_imm || f7_zero || f7_alt;
                  if (!is_imm && f7_alt) dec_op = ALU_OP_SUB;
               end
               3'b001: begin
                  dec_op     = ALU_OP_SLL;
                  dec_legal  = f7_zero;
                  dec_rs2[5] = 1'b0;
               end
               3'b101: begin
                  dec_legal  = f7_zero || f7_alt;
                  dec_rs2[5] = 1'b0;
                  if (f7_alt) begin
                     dec_op  = ALU_OP_SRA;
                     dec_rs1 = {{(XPR_LEN-W_LEN){bus.in_rs1_val[W_LEN-1]}}, bus.in_rs1_val[W_LEN-1:0]};
                  end else begin
                     dec_op  = ALU_OP_SRL;
                     dec_rs1 = {{(XPR_LEN-W_LEN){1'b0}}, bus.in_rs1_val[W_LEN-1:0]};
                  end
               end
               default: dec_legal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            dec_legal = 1'b1;
            dec_rs1   = '0;
            dec_rs2   = bus.in_imm;
         end
         OPC_AUIPC: begin
            dec_legal = 1'b1;
            dec_rs1   = bus.in_pc;
            dec_rs2   = bus.in_imm;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Control FSM: accept, pulse the ALU for one cycle, capture its registered
   // result, then hold the writeback until the register file takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         op_r   <= '0;
         rs1_r  <= '0;
         rs2_r  <= '0;
         en_r   <= 1'b0;
         w_r    <= 1'b0;
         rd_r   <= '0;
         we_r   <= 1'b0;
         ill_r  <= 1'b0;
         data_r <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  rd_r   <= bus.in_rd;
                  we_r   <= dec_legal && (bus.in_rd != 5'd0);
                  ill_r  <= !dec_legal;
                  w_r    <= dec_w;
                  data_r <= '0;
                  if (dec_legal) begin
                     en_r  <= 1'b1;
                     op_r  <= dec_op;
                     rs1_r <= dec_rs1;
                     rs2_r <= dec_rs2;
                     state <= ST_ISSUE;
                  end else begin
                     state <= ST_WB;
                  end
               end
            end
            ST_ISSUE: begin
               en_r  <= 1'b0;
               op_r  <= '0;
               rs1_r <= '0;
               rs2_r <= '0;
               state <= ST_CAPT;
            end
            ST_CAPT: begin
               data_r <= w_r ? {{(XPR_LEN-W_LEN){bus.alu_rd[W_LEN-1]}}, bus.alu_rd[W_LEN-1:0]}
                             : bus.alu_rd;
               state  <= ST_WB;
            end
            default: begin
               if (bus.wb_ready) begin
                  rd_r   <= '0;
                  we_r   <= 1'b0;
                  ill_r  <= 1'b0;
                  data_r <= '0;
                  state  <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.in_ready   = (state == ST_IDLE);
   assign bus.busy       = (state != ST_IDLE);
   assign bus.wb_valid   = (state == ST_WB);
   assign bus.alu_en     = en_r;
   assign bus.alu_op     = op_r;
   assign bus.alu_rs1    = rs1_r;
   assign bus.alu_rs2    = rs2_r;
   assign bus.wb_rd      = rd_r;
   assign bus.wb_we      = we_r;
   assign bus.wb_illegal = ill_r;
   assign bus.wb_data    = data_r;
endmodule
